// File: rtl/pll_lock_sequencer_pkg.sv
// State encodings for the PLL lock sequencer, shared with the status/debug register block.
package pll_lock_sequencer_pkg;

  localparam logic [2:0] ST_RST_PULSE = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  // PLL is held in reset while pulsing and while parked in FAIL
  function automatic logic holds_pll_reset(input logic [2:0] st);
    return (st == ST_RST_PULSE) || (st == ST_FAIL);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Reset-to-0 two-flop synchronizer for a single asynchronous input.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rPLL reset/lock sequencer: pulses pll_reset, debounces lock, releases sys_rst_n, retries and
// re-sequences on lock loss. Runs on the reference clock.
module pll_lock_sequencer
  import pll_lock_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 2700,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16,
  parameter int RTY_W         = 4
) (
  input  logic             clkin,
  input  logic             reset_n,
  input  logic             pll_lock,
  input  logic             restart,
  output logic             pll_reset,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             fail,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [7:0]       lock_loss_cnt,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK edge that first sees lock counts as stable clock one, so release lands on
  // the edge that sees the STABLE_CYCLES-th consecutive synced lock (e0 + STABLE_CYCLES + 1).
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  logic             lock_s;
  logic             lost;
  logic [CNT_W-1:0] tmo_cnt, tmo_nx;
  logic [CNT_W-1:0] stb_cnt, stb_nx;
  logic [RTY_W-1:0] rty_nx;
  logic [7:0]       llc_nx;
  logic [2:0]       state_nx;

  sync_2ff u_lock_sync (
    .clk   (clkin),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign lost = (state == ST_RUN) && !lock_s;

  always_comb begin
    state_nx = state;
    tmo_nx   = tmo_cnt;
    stb_nx   = stb_cnt;
    rty_nx   = retry_cnt;
    // loss is counted even when a restart lands on the same edge
    llc_nx   = (lost && lock_loss_cnt != 8'hFF) ? lock_loss_cnt + 8'd1 : lock_loss_cnt;
    if (restart) begin
      state_nx = ST_RST_PULSE;
      tmo_nx   = '0;
      stb_nx   = '0;
      rty_nx   = '0;
    end else begin
      case (state)
        ST_RST_PULSE: begin
          if (tmo_cnt == RST_LAST) begin
            state_nx = ST_WAIT_LOCK;
            tmo_nx   = '0;
          end else begin
            tmo_nx = tmo_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          // tmo_cnt survives lock chatter so a flapping PLL still times out
          tmo_nx = tmo_cnt + CNT_W'(1);
          if (tmo_cnt == TMO_LAST) begin
            tmo_nx = '0;
            stb_nx = '0;
            if (retry_cnt < RTY_MAX) begin
              rty_nx   = retry_cnt + RTY_W'(1);
              state_nx = ST_RST_PULSE;
            end else begin
              state_nx = ST_FAIL;
            end
          end else if (!lock_s) begin
            state_nx = ST_WAIT_LOCK;
            stb_nx   = '0;
          end else if (state == ST_WAIT_LOCK) begin
            state_nx = ST_STABLE;
            stb_nx   = '0;
          end else if (stb_cnt == STB_LAST) begin
            state_nx = ST_RUN;
          end else begin
            stb_nx = stb_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (lost) begin
            state_nx = ST_RST_PULSE;
            tmo_nx   = '0;
            stb_nx   = '0;
            rty_nx   = '0;
          end
        end
        ST_FAIL: ;
        default: begin
          state_nx = ST_RST_PULSE;
          tmo_nx   = '0;
          stb_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_RST_PULSE;
      tmo_cnt       <= '0;
      stb_cnt       <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_reset     <= 1'b1;
      sys_rst_n     <= 1'b0;
      ready         <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state         <= state_nx;
      tmo_cnt       <= tmo_nx;
      stb_cnt       <= stb_nx;
      retry_cnt     <= rty_nx;
      lock_loss_cnt <= llc_nx;
      pll_reset     <= holds_pll_reset(state_nx);
      sys_rst_n     <= (state_nx == ST_RUN);
      ready         <= (state_nx == ST_RUN);
      fail          <= (state_nx == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized bench for pll_lock_sequencer against a phase/run-length reference model.
module tb_pll_lock_sequencer;

  localparam int RSTC = 4;
  localparam int TMO  = 40;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  localparam int PM_NOM   = 0;
  localparam int PM_NEVER = 1;
  localparam int PM_CHAT  = 2;

  typedef enum {M_PULSE, M_ACQ, M_RUN, M_FAIL} mph_t;

  logic       clkin, reset_n, pll_lock, restart;
  logic       pll_reset, sys_rst_n, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  pll_lock_sequencer #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STB),
    .MAX_RETRY(MAXR), .CNT_W(16), .RTY_W(4)
  ) dut (
    .clkin(clkin), .reset_n(reset_n), .pll_lock(pll_lock), .restart(restart),
    .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt), .state(state)
  );

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // PLL behaviour: lock comes dly clocks after pll_reset falls; optional chatter and drops
  int pmode = PM_NOM;
  int dly_lo = 10, dly_hi = 10;
  int dly = 10;
  int since = 0;
  int drops_req = 0, drops_done = 0;

  always @(negedge clkin) begin
    logic lk;
    lk = 1'b0;
    if (pll_reset) begin
      since = 0;
      dly   = $urandom_range(dly_hi, dly_lo);
    end else begin
      since++;
      case (pmode)
        PM_NOM:  lk = (since >= dly);
        PM_CHAT: lk = (since >= dly) && (((since - dly) / 5) % 2 == 0);
        default: lk = 1'b0;
      endcase
    end
    if (drops_req != drops_done) begin
      lk = 1'b0;
      drops_done++;
    end
    pll_lock = lk;
  end

  // Reference model: sequence phases, time spent in acquisition, run length of synced lock
  mph_t m_ph;
  int   m_el, m_run, m_rty, m_llc;
  logic d1, d2, ls, pl_prev;
  int   cyc = 0, e0_cyc = 0, rise_cyc = 0;
  logic srn_prev = 1'b0;

  always @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = M_PULSE; m_el = 0; m_run = 0; m_rty = 0; m_llc = 0;
      d1 = 1'b0; d2 = 1'b0; pl_prev = 1'b0;
    end else begin
      cyc++;
      if (pll_lock && !pl_prev) e0_cyc = cyc;
      pl_prev = pll_lock;
      ls = d2; d2 = d1; d1 = pll_lock;
      if (restart) begin
        if (m_ph == M_RUN && !ls && m_llc < 255) m_llc++;
        m_ph = M_PULSE; m_el = 0; m_rty = 0;
      end else begin
        case (m_ph)
          M_PULSE: if (m_el == RSTC - 1) begin m_ph = M_ACQ; m_el = 0; m_run = 0; end
                   else m_el++;
          M_ACQ: begin
            m_run = ls ? m_run + 1 : 0;
            if (m_el == TMO - 1) begin
              m_el = 0;
              if (m_rty < MAXR) begin m_rty++; m_ph = M_PULSE; end
              else m_ph = M_FAIL;
            end else if (m_run == STB) m_ph = M_RUN;
            else m_el++;
          end
          M_RUN: if (!ls) begin
            if (m_llc < 255) m_llc++;
            m_rty = 0; m_ph = M_PULSE; m_el = 0;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic int exp_state();
    case (m_ph)
      M_PULSE: return 0;
      M_ACQ:   return (m_run > 0) ? 2 : 1;
      M_RUN:   return 3;
      default: return 4;
    endcase
  endfunction

  task automatic tick();
    @(negedge clkin);
    chk("state", 32'(state), exp_state());
    chk("pll_reset", 32'(pll_reset), 32'(m_ph == M_PULSE || m_ph == M_FAIL));
    chk("sys_rst_n", 32'(sys_rst_n), 32'(m_ph == M_RUN));
    chk("ready", 32'(ready), 32'(m_ph == M_RUN));
    chk("fail", 32'(fail), 32'(m_ph == M_FAIL));
    chk("retry_cnt", 32'(retry_cnt), m_rty);
    chk("lock_loss_cnt", 32'(lock_loss_cnt), m_llc);
    if (sys_rst_n && !srn_prev) rise_cyc = cyc;
    srn_prev = sys_rst_n;
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin tick(); n++; end
    chk("ready_timeout", 32'(ready), 1);
  endtask

  // async reset between clock edges: outputs must already hold reset values
  task automatic reset_mid_cycle(input string tag);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_pll_reset"}, 32'(pll_reset), 1);
    chk({tag, "_sys_rst_n"}, 32'(sys_rst_n), 0);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_fail"}, 32'(fail), 0);
    chk({tag, "_retry"}, 32'(retry_cnt), 0);
    chk({tag, "_llc"}, 32'(lock_loss_cnt), 0);
    tick(); tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    logic saw;
    reset_n = 1'b0; restart = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // nominal lock, 10 clocks after pll_reset falls
    wait_ready(200);
    chk("lock_to_run", rise_cyc - e0_cyc, STB + 1);
    chk("rty_nominal", 32'(retry_cnt), 0);
    repeat (20) tick();

    // never locks: three attempts then FAIL
    pmode = PM_NEVER;
    do_reset();
    repeat (200) tick();
    chk("fail_state", 32'(state), 4);
    chk("fail_sticky", 32'(fail), 1);
    chk("fail_retry", 32'(retry_cnt), MAXR);
    chk("fail_pll_reset", 32'(pll_reset), 1);

    // restart out of FAIL
    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_fail_clr", 32'(fail), 0);
    chk("restart_fail_rty", 32'(retry_cnt), 0);

    // restart on the same edge as a timeout with one retry used
    n = 0;
    while (!(m_ph == M_ACQ && m_rty == 1 && m_el == TMO - 1) && n < 300) begin tick(); n++; end
    chk("align_timeout", 32'(n < 300), 1);
    restart = 1'b1; tick(); restart = 1'b0;
    chk("restart_tmo_rty", 32'(retry_cnt), 0);
    chk("restart_tmo_state", 32'(state), 0);

    // chatter in STABLE never reaches RUN
    pmode = PM_CHAT;
    do_reset();
    saw = 1'b0;
    repeat (300) begin tick(); if (ready || sys_rst_n) saw = 1'b1; end
    chk("chatter_no_run", 32'(saw), 0);

    // repeated lock losses, counter saturates
    pmode = PM_NOM; dly_lo = 3; dly_hi = 15;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      wait_ready(200);
      drops_req++;
      repeat (4) tick();
    end
    wait_ready(200);
    chk("llc_saturate", 32'(lock_loss_cnt), 255);

    // async reset mid-STABLE and mid-RUN
    dly_lo = 10; dly_hi = 10;
    do_reset();
    n = 0;
    while (!(m_ph == M_ACQ && m_run > 2) && n < 200) begin tick(); n++; end
    chk("reach_stable", 32'(state), 2);
    reset_mid_cycle("rst_stable");
    wait_ready(200);
    drops_req++;
    repeat (4) tick();
    wait_ready(200);
    reset_mid_cycle("rst_run");

    // randomized mix of PLL behaviours, restarts and drops
    for (int i = 0; i < 4000; i++) begin
      if (i % 300 == 0) begin
        int r;
        r = $urandom_range(5, 0);
        pmode = (r < 4) ? PM_NOM : (r == 4) ? PM_NEVER : PM_CHAT;
        dly_lo = 1; dly_hi = 45;
      end
      restart = ($urandom_range(199, 0) == 0);
      if (ready && $urandom_range(29, 0) == 0) drops_req++;
      tick();
    end
    restart = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
